// File: rtl/peridot_servo_pwmcap.sv
// peridot_servo_pwmcap: RC servo pulse-width capture channel.
// Measures the high time of pwm_in in servo steps (pwm_timing ticks) and
// converts it to the 8-bit servo width code (0 min, 128 centre, 255 max).
// Also flags a lost signal after a run of ticks with no valid capture.
// Optional build macro PERIDOT_PWMCAP_FILTER_EN inserts a 3-sample majority
// glitch filter after the synchronizer; this adds 2 clk of latency.
module peridot_servo_pwmcap #(
   parameter int MINWIDTHSTEP = 64,
   parameter int MAXPULSESTEP = 512,
   parameter int TIMEOUTSTEP  = 7680
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cap_enable,
   input  logic       pwm_timing,
   input  logic       pwm_in,
   input  logic       reg_read,
   output logic [7:0] reg_readdata,
   output logic       cap_update,
   output logic       cap_update_flag,
   output logic       cap_valid,
   output logic       signal_lost
);

   localparam int            TW     = $clog2(TIMEOUTSTEP + 1);
   localparam logic [9:0]    MIN_W  = 10'(MINWIDTHSTEP);
   localparam logic [9:0]    MAX_W  = 10'(MAXPULSESTEP);
   localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUTSTEP);
   localparam logic [TW-1:0] TO_PRE = TW'(TIMEOUTSTEP - 1);

   typedef enum logic [1:0] {ARM, LOW, HIGH} state_t;

   state_t        state;
   logic          sync1, sync2;
   logic          line, line_d, rise_p, fall_p;
   logic [9:0]    wcnt;
   logic [TW-1:0] tcnt;

   // Width count to servo code: below minimum is 0, above range saturates.
   function automatic logic [7:0] width_code(input logic [9:0] c);
      logic [9:0] w;
      if (c < MIN_W) return 8'd0;
      w = c - MIN_W;
      if (w > 10'd255) return 8'hFF;
      return w[7:0];
   endfunction

   // Two-flop synchronizer. Resetting high means a line that is already high
   // out of reset never looks like a fresh rising edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= pwm_in;
         sync2 <= sync1;
      end
   end

`ifdef PERIDOT_PWMCAP_FILTER_EN
   logic hist1, hist2, filt;

   // Majority of the last three synchronized samples: one-clk glitches vanish.
   always_ff @(posedge clk) begin
      if (reset) begin
         hist1 <= 1'b1;
         hist2 <= 1'b1;
         filt  <= 1'b1;
      end else begin
         hist1 <= sync2;
         hist2 <= hist1;
         filt  <= (sync2 & hist1) | (sync2 & hist2) | (hist1 & hist2);
      end
   end

   assign line = filt;
`else
   assign line = sync2;
`endif

   // Registered edge detector; line_d is the level the FSM qualifies on.
   always_ff @(posedge clk) begin
      if (reset) begin
         line_d <= 1'b1;
         rise_p <= 1'b0;
         fall_p <= 1'b0;
      end else begin
         line_d <= line;
         rise_p <= line & ~line_d;
         fall_p <= ~line & line_d;
      end
   end

   // Capture FSM, timeout counter and all registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= ARM;
         wcnt            <= '0;
         tcnt            <= '0;
         reg_readdata    <= 8'd128;
         cap_update      <= 1'b0;
         cap_update_flag <= 1'b0;
         cap_valid       <= 1'b0;
         signal_lost     <= 1'b1;
      end else if (!cap_enable) begin
         state       <= ARM;
         wcnt        <= '0;
         tcnt        <= '0;
         cap_update  <= 1'b0;
         cap_valid   <= 1'b0;
         signal_lost <= 1'b1;
         if (reg_read) cap_update_flag <= 1'b0;
      end else begin
         cap_update <= 1'b0;
         if (reg_read) cap_update_flag <= 1'b0;

         // Timeout runs in every state; a capture below overrides it.
         if (pwm_timing && tcnt != TO_MAX) begin
            tcnt <= tcnt + 1'b1;
            if (tcnt == TO_PRE) begin
               signal_lost  <= 1'b1;
               cap_valid    <= 1'b0;
               reg_readdata <= 8'd128;
            end
         end

         case (state)
            ARM: if (!line_d) state <= LOW;
            LOW: if (rise_p) begin
               wcnt  <= '0;
               state <= HIGH;
            end
            HIGH: begin
               // Falling edge wins over a coincident tick.
               if (fall_p) begin
                  reg_readdata    <= width_code(wcnt);
                  cap_update      <= 1'b1;
                  cap_update_flag <= 1'b1;
                  cap_valid       <= 1'b1;
                  signal_lost     <= 1'b0;
                  tcnt            <= '0;
                  state           <= LOW;
               end else if (pwm_timing) begin
                  if (wcnt == MAX_W) state <= ARM;
                  else               wcnt  <= wcnt + 1'b1;
               end
            end
            default: state <= ARM;
         endcase
      end
   end

endmodule
